// File: rtl/grayscale_pkg.sv
// Shared definitions for the RGB-to-gray pipeline: pixel modes, luma weights, channel positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package grayscale_pkg;

    // Per-pixel conversion mode, sampled together with each popped pixel.
    typedef enum logic [1:0] {
        MODE_AVG    = 2'd0,
        MODE_LUMA   = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_THRESH = 2'd3
    } mode_t;

    // Luma weights sum to 256, so a shift of 8 keeps the result in channel range.
    localparam logic [7:0] LUMA_R_WEIGHT = 8'd77;
    localparam logic [7:0] LUMA_G_WEIGHT = 8'd150;
    localparam logic [7:0] LUMA_B_WEIGHT = 8'd29;
    localparam int         LUMA_SHIFT    = 8;

    // Bit positions of the channels in a packed pixel: R high, G middle, B at bit 0.
    function automatic int r_lsb(input int w);
        return 2 * w;
    endfunction

    function automatic int g_lsb(input int w);
        return w;
    endfunction

endpackage

// File: rtl/gray_calc.sv
// Registered gray-value stage: average, luma, threshold or bypass of one pixel.
// Latency: 1 cycle from enable-qualified input to registered output.
// Backpressure: holds all outputs while enable is low.
//
// Ports: clock/reset (async, active-high); enable advances the stage; valid_in,
// pix_in, mode_in, thr_in describe the incoming pixel; valid_out, g_out (final
// gray level, threshold already resolved), pix_out (unchanged pixel) and
// bypass_out (pixel must pass through untouched) describe the registered result.
module gray_calc
    import grayscale_pkg::*;
#(
    parameter int CHANNEL_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     valid_in,
    input  logic [3*CHANNEL_W-1:0]   pix_in,
    input  logic [1:0]               mode_in,
    input  logic [CHANNEL_W-1:0]     thr_in,
    output logic                     valid_out,
    output logic [CHANNEL_W-1:0]     g_out,
    output logic [3*CHANNEL_W-1:0]   pix_out,
    output logic                     bypass_out
);

    localparam int W = CHANNEL_W;

    logic [W-1:0] red;
    logic [W-1:0] green;
    logic [W-1:0] blue;
    logic [W+1:0] sum3;
    logic [W+7:0] luma_sum;
    logic [W-1:0] avg_g;
    logic [W-1:0] luma_g;
    logic [W-1:0] calc_g;

    assign red   = pix_in[r_lsb(W) +: W];
    assign green = pix_in[g_lsb(W) +: W];
    assign blue  = pix_in[W-1:0];

    always_comb begin
        // Sum of three channels needs two extra bits; constant divide is exact.
        sum3     = (W+2)'(red) + (W+2)'(green) + (W+2)'(blue);
        avg_g    = W'(sum3 / (W+2)'(3));
        luma_sum = (W+8)'(red)   * (W+8)'(LUMA_R_WEIGHT)
                 + (W+8)'(green) * (W+8)'(LUMA_G_WEIGHT)
                 + (W+8)'(blue)  * (W+8)'(LUMA_B_WEIGHT);
        luma_g   = W'(luma_sum >> LUMA_SHIFT);
        calc_g   = '0;
        case (mode_t'(mode_in))
            MODE_AVG:    calc_g = avg_g;
            MODE_LUMA:   calc_g = luma_g;
            MODE_THRESH: calc_g = (luma_g >= thr_in) ? '1 : '0;
            MODE_BYPASS: calc_g = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_out  <= 1'b0;
            g_out      <= '0;
            pix_out    <= '0;
            bypass_out <= 1'b0;
        end else if (enable) begin
            valid_out <= valid_in;
            if (valid_in) begin
                g_out      <= calc_g;
                pix_out    <= pix_in;
                bypass_out <= (mode_t'(mode_in) == MODE_BYPASS);
            end
        end
    end

endmodule

// File: rtl/grayscale_pipe.sv
// Streaming RGB-to-gray converter between an input and an output FWFT FIFO, with frame counter.
// Latency: 3 cycles from the rd_en cycle to the wr_en cycle; 1 pixel per clock sustained.
// Backpressure: out_valid & fifo_out_full freezes every stage and blocks pops; nothing is lost.
//
// Ports: clock/reset (async, active-high); mode/threshold sampled with each pop;
// fifo_in_* pops the input FIFO; fifo_out_* pushes the output FIFO;
// pixel_index counts writes in the current frame; frame_done marks the last write.
module grayscale_pipe
    import grayscale_pkg::*;
#(
    parameter int CHANNEL_W       = 8,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FRAME_PIXELS    = 307200,
    parameter int CNT_W           = $clog2(FRAME_PIXELS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  mode,
    input  logic [CHANNEL_W-1:0]        threshold,
    output logic                        fifo_in_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0]  fifo_in_dout,
    input  logic                        fifo_in_empty,
    output logic                        fifo_out_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0]  fifo_out_din,
    input  logic                        fifo_out_full,
    output logic [CNT_W-1:0]            pixel_index,
    output logic                        frame_done
);

    localparam int              W          = CHANNEL_W;
    localparam int              PW         = 3 * CHANNEL_W;
    localparam logic [CNT_W-1:0] LAST_INDEX = CNT_W'(FRAME_PIXELS - 1);

    logic                       stall;
    logic                       out_valid;
    logic [FIFO_DATA_WIDTH-1:0] out_data;

    logic                       s1_valid;
    logic [PW-1:0]              s1_pix;
    logic [1:0]                 s1_mode;
    logic [W-1:0]               s1_thr;

    logic                       s2_valid;
    logic [W-1:0]               s2_g;
    logic [PW-1:0]              s2_pix;
    logic                       s2_bypass;
    logic [FIFO_DATA_WIDTH-1:0] s2_word;

    // Bits above the three channels carry nothing for this block.
    if (FIFO_DATA_WIDTH > PW) begin : g_in_hi
        logic unused_in_hi;
        assign unused_in_hi = ^fifo_in_dout[FIFO_DATA_WIDTH-1:PW];
    end

    assign stall          = out_valid & fifo_out_full;
    // Reset gates the pop directly so no pixel is consumed while the pipe is held clear.
    assign fifo_in_rd_en  = !reset & !stall & !fifo_in_empty;
    assign fifo_out_wr_en = out_valid & !fifo_out_full;
    assign fifo_out_din   = out_data;
    assign frame_done     = fifo_out_wr_en & (pixel_index == LAST_INDEX);

    // S1: capture popped pixel together with its mode and threshold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_mode  <= '0;
            s1_thr   <= '0;
        end else if (!stall) begin
            s1_valid <= fifo_in_rd_en;
            if (fifo_in_rd_en) begin
                s1_pix  <= fifo_in_dout[PW-1:0];
                s1_mode <= mode;
                s1_thr  <= threshold;
            end
        end
    end

    // S2: gray computation.
    gray_calc #(
        .CHANNEL_W (CHANNEL_W)
    ) u_gray_calc (
        .clock      (clock),
        .reset      (reset),
        .enable     (!stall),
        .valid_in   (s1_valid),
        .pix_in     (s1_pix),
        .mode_in    (s1_mode),
        .thr_in     (s1_thr),
        .valid_out  (s2_valid),
        .g_out      (s2_g),
        .pix_out    (s2_pix),
        .bypass_out (s2_bypass)
    );

    always_comb begin
        s2_word         = '0;
        s2_word[PW-1:0] = s2_bypass ? s2_pix : {3{s2_g}};
    end

    // S3: output register. When not stalled, any held word has just been written,
    // so out_valid simply follows S2.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= s2_word;
            end
        end
    end

    // Frame counter advances only on an actual output write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_index <= '0;
        end else if (fifo_out_wr_en) begin
            pixel_index <= (pixel_index == LAST_INDEX) ? '0 : pixel_index + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed bench for grayscale_pipe with a small FWFT input FIFO model and an output write log.
// Latency: n/a.
// Backpressure: fifo_out_full driven directly by the stimulus.
module tb_grayscale_pipe;

    logic        clock;
    logic        reset;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic        fifo_in_rd_en;
    logic [31:0] fifo_in_dout;
    logic        fifo_in_empty;
    logic        fifo_out_wr_en;
    logic [31:0] fifo_out_din;
    logic        fifo_out_full;
    logic [1:0]  pixel_index;
    logic        frame_done;

    grayscale_pipe #(
        .CHANNEL_W       (8),
        .FIFO_DATA_WIDTH (32),
        .FRAME_PIXELS    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mode           (mode),
        .threshold      (threshold),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_in_dout   (fifo_in_dout),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_wr_en (fifo_out_wr_en),
        .fifo_out_din   (fifo_out_din),
        .fifo_out_full  (fifo_out_full),
        .pixel_index    (pixel_index),
        .frame_done     (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Input FIFO model: array with read/write pointers.
    logic [31:0] in_mem [0:63];
    int          in_wr = 0;
    int          in_rd = 0;

    assign fifo_in_empty = (in_rd == in_wr);
    assign fifo_in_dout  = in_mem[in_rd[5:0]];

    always @(posedge clock) begin
        if (fifo_in_rd_en) in_rd <= in_rd + 1;
    end

    // Cycle counter and negedge monitor of pops and writes.
    int          cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          rd_cyc [0:63];
    int          wr_cyc [0:63];
    logic [31:0] wr_dat [0:63];
    logic        wr_done [0:63];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (fifo_in_rd_en && n_rd < 64) begin
            rd_cyc[n_rd] <= cyc;
            n_rd <= n_rd + 1;
        end
        if (fifo_out_wr_en && n_wr < 64) begin
            wr_dat[n_wr]  <= fifo_out_din;
            wr_cyc[n_wr]  <= cyc;
            wr_done[n_wr] <= frame_done;
            n_wr <= n_wr + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        in_mem[in_wr[5:0]] = v;
        in_wr++;
    endtask

    // Wait (bounded) until the write log reaches target, then confirm no extra writes.
    task automatic wait_wr(input int target, input string tag);
        int k;
        k = 0;
        while (n_wr < target && k < 200) begin
            step();
            k++;
        end
        repeat (6) step();
        chk(tag, n_wr, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int wb;
    int rb;

    initial begin
        reset         = 1'b1;
        mode          = 2'd0;
        threshold     = 8'h00;
        fifo_out_full = 1'b0;
        #3;
        chk("rst_wr_en", fifo_out_wr_en, 0);
        chk("rst_din", fifo_out_din, 0);
        chk("rst_index", pixel_index, 0);
        chk("rst_done", frame_done, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Average; upper input byte must be ignored.
        mode = 2'd0;
        wb = n_wr; rb = n_rd;
        push(32'h00FF0000);
        push(32'hAB030201);
        wait_wr(wb + 2, "avg_count");
        chk("avg_red", wr_dat[wb], 32'h00555555);
        chk("avg_small", wr_dat[wb+1], 32'h00020202);
        chk("avg_latency", wr_cyc[wb] - rd_cyc[rb], 3);

        // Luma.
        mode = 2'd1;
        wb = n_wr;
        push(32'h00FFFFFF);
        push(32'h00FF0000);
        push(32'h0000FF00);
        wait_wr(wb + 3, "luma_count");
        chk("luma_white", wr_dat[wb], 32'h00FFFFFF);
        chk("luma_red", wr_dat[wb+1], 32'h004C4C4C);
        chk("luma_green", wr_dat[wb+2], 32'h00959595);

        // Threshold, then switch to bypass while the first pixels are in flight.
        mode = 2'd3;
        threshold = 8'h80;
        wb = n_wr;
        push(32'h00808080);
        push(32'h007F7F7F);
        step();
        step();
        mode = 2'd2;
        threshold = 8'h00;
        push(32'h00123456);
        push(32'h00808080);
        wait_wr(wb + 4, "thr_count");
        chk("thr_at_level", wr_dat[wb], 32'h00FFFFFF);
        chk("thr_below", wr_dat[wb+1], 32'h00000000);
        chk("byp_pixel", wr_dat[wb+2], 32'h00123456);
        chk("byp_not_thr", wr_dat[wb+3], 32'h00808080);

        // Back-pressure: 10 pixels, output full for 5 cycles mid-stream.
        wb = n_wr;
        for (int i = 0; i < 10; i++) push(32'h00C00000 + i);
        repeat (5) step();
        fifo_out_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("bp_rd_en_%0d", i), fifo_in_rd_en, 0);
            chk($sformatf("bp_wr_en_%0d", i), fifo_out_wr_en, 0);
            step();
        end
        fifo_out_full = 1'b0;
        wait_wr(wb + 10, "bp_count");
        for (int i = 0; i < 10; i++) chk($sformatf("bp_data_%0d", i), wr_dat[wb+i], 32'h00C00000 + i);

        // Reset with three pixels in flight; a pixel waiting during reset must not be popped.
        wb = n_wr;
        push(32'h00111111);
        push(32'h00222222);
        push(32'h00333333);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", fifo_out_wr_en, 0);
        chk("mid_rst_din", fifo_out_din, 0);
        chk("mid_rst_index", pixel_index, 0);
        push(32'h00ABCDEF);
        #1;
        chk("mid_rst_rd_en", fifo_in_rd_en, 0);
        step();
        step();
        chk("mid_rst_no_wr", n_wr, wb);
        reset = 1'b0;
        wait_wr(wb + 1, "post_rst_count");
        chk("post_rst_data", wr_dat[wb], 32'h00ABCDEF);
        chk("post_rst_index", pixel_index, 1);

        // Frame counter with FRAME_PIXELS = 4: nine writes.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        wb = n_wr;
        for (int i = 0; i < 9; i++) push(32'h000A0000 + i);
        wait_wr(wb + 9, "frame_count");
        for (int i = 0; i < 9; i++)
            chk($sformatf("frame_done_%0d", i + 1), wr_done[wb+i], (i == 3 || i == 7) ? 1 : 0);
        chk("frame_index", pixel_index, 1);
        chk("frame_last_data", wr_dat[wb+8], 32'h000A0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grayscale_pipe.md
Name: grayscale_pipe

Overview:
Streaming RGB-to-gray converter between an input and an output first-word-fall-through FIFO. It sustains one pixel per clock and stalls under output back-pressure with no loss. Per-pixel mode select chooses average, luma, bypass or threshold. A frame counter reports pixel position and pulses at end of frame.

Parameters:
CHANNEL_W, 8, bits per colour channel
FIFO_DATA_WIDTH, 32, FIFO word width; must be >= 3*CHANNEL_W
FRAME_PIXELS, 307200, pixels per frame (>= 2); sets the frame counter wrap point
CNT_W, $clog2(FRAME_PIXELS), width of pixel_index

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
mode  in  2  0=average, 1=luma, 2=bypass, 3=threshold; sampled with each pixel pop
threshold  in  CHANNEL_W  mode-3 comparison level; sampled with each pixel pop
fifo_in_rd_en  out  1  pop input FIFO
fifo_in_dout  in  FIFO_DATA_WIDTH  input pixel, valid while !fifo_in_empty
fifo_in_empty  in  1  input FIFO empty
fifo_out_wr_en  out  1  push output FIFO
fifo_out_din  out  FIFO_DATA_WIDTH  output pixel
fifo_out_full  in  1  output FIFO full
pixel_index  out  CNT_W  count of pixels written in the current frame
frame_done  out  1  one-cycle pulse on the write of the last pixel of a frame

Behaviour:
- Pixel layout: R=[3W-1:2W], G=[2W-1:W], B=[W-1:0], where W=CHANNEL_W. Input bits above 3W are ignored. Output bits above 3W are driven 0.
- Pipeline stages:
  - S1 registers the popped pixel, mode and threshold.
  - S2 computes the gray value.
  - S3 is the output register (out_data, out_valid).
  - Each stage has its own valid bit.
- stall = out_valid & fifo_out_full. All stage registers hold while stall is high.
- When stall is low, every stage advances. A bubble enters S1 if no pop occurs.
- fifo_in_rd_en = !stall & !fifo_in_empty (combinational). fifo_in_dout is captured into S1 on the same edge.
- fifo_out_wr_en = out_valid & !fifo_out_full (combinational). fifo_out_din = out_data.
- out_valid clears when a write happens and no new pixel arrives from S2.
- Latency: a pixel popped on edge N is presented with wr_en high after edge N+3 when the output is not full.
- Throughput: 1 pixel/cycle with a continuous, non-full stream.
- Arithmetic per mode (result g is W bits, replicated into all three channels):
  - avg: g = floor((R+G+B)/3). The sum is W+2 bits. The division must be exact for all inputs; either a divider or a correctly sized multiply-shift is acceptable.
  - luma: g = (77R + 150G + 29B) >> 8. The sum is W+8 bits. Weights total 256, so there is no overflow.
  - bypass: the pixel passes through unchanged (low 3W bits).
  - threshold: luma is computed first; output channels are all-ones if luma >= threshold, else 0.
- Changing mode or threshold mid-stream affects only pixels popped afterwards. In-flight pixels keep their sampled mode.
- Frame counter:
  - Increments on every output write.
  - On the write when pixel_index == FRAME_PIXELS-1, frame_done pulses high for that cycle and pixel_index wraps to 0.
  - No writes means no change.
- Reset (asynchronous, including mid-stream):
  - All valid bits clear; fifo_out_din=0; pixel_index=0; frame_done=0.
  - fifo_in_rd_en and fifo_out_wr_en go low immediately.
  - Pixels already popped are discarded.
  - Operation resumes on the first clock edge after reset deasserts.
- Simultaneous pop and write in the same cycle is normal operation; no priority is needed.
- fifo_out_full rising while out_valid: data holds and no pop occurs until full falls.
- Empty input with a non-full output: the pipeline drains and bubbles propagate.

Decomposition:
- Package grayscale_pkg holds:
  - mode constants MODE_AVG/MODE_LUMA/MODE_BYPASS/MODE_THRESH
  - luma weights 77/150/29 and the shift of 8
  - channel bit-position helpers
- Sub-module gray_calc is a registered S2 stage. It takes pixel, mode and threshold plus an enable, and returns g plus a pass-through pixel. The frame counter stays inline.

Test Plan:
- Avg mode: pop 0x00FF0000 -> write 0x00555555 exactly 3 cycles after rd_en; 0x00030201 -> 0x00020202.
- Luma mode: 0x00FFFFFF -> 0x00FFFFFF; 0x00FF0000 -> 0x004C4C4C (77*255>>8=76); 0x0000FF00 -> 0x00959595.
- Threshold mode, threshold=0x80: 0x00808080 -> 0x00FFFFFF; 0x007F7F7F -> 0x00000000. Switching to bypass mid-stream: 0x00123456 -> 0x00123456 only for pixels popped after the switch.
- Back-pressure: stream 10 distinct pixels, hold fifo_out_full for 5 cycles mid-stream -> rd_en low while stalled, exactly 10 writes, order preserved, no duplicates.
- Frame counter, FRAME_PIXELS=4: write 9 pixels -> frame_done on the 4th and 8th writes only; final pixel_index=1.
- Reset asserted with 3 pixels in flight -> wr_en/rd_en low same cycle, fifo_out_din=0, pixel_index=0, no writes until new pixels are popped.
